// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame geometry, FSM states,
// and a counter-width helper.
package uart_rx_pkg;

    localparam int unsigned UartDataBits = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } rx_state_e;

    // Keep at least one bit, even for degenerate divider values.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for an asynchronous input pin; both flops take
// RESET_VAL on reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, finds the start edge, samples each bit at
// mid-bit and emits one-cycle valid / frame-error strobes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    output logic [UartDataBits-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    rx_frame_err,
    output logic                    rx_busy
);

    localparam int unsigned     CntW    = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic                    rx_s;
    rx_state_e               state_q;
    logic [CntW-1:0]         cnt_q;
    logic [2:0]              bidx_q;
    logic [UartDataBits-1:0] shift_q;
    logic [UartDataBits-1:0] data_q;
    logic                    valid_q;
    logic                    ferr_q;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The first low sample is already sample 0 of the start bit.
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= CntOne;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfCnt) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= StData;
                            bidx_q  <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StData: begin
                    if (cnt_q == LastCnt) begin
                        shift_q[bidx_q] <= rx_s;
                        cnt_q           <= '0;
                        if (bidx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bidx_q <= bidx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StStop: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StBreak: begin
                    // A held-low line must not look like a stream of start bits.
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != StIdle);

endmodule
